// File: rtl/wfd_wb_pkg.sv
// Shared Wishbone poller definitions: FSM state encoding, default timing
// parameters and the data word used by the clearing write.
package wfd_wb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RD_GAP = 3'd2,
    WR     = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int unsigned DEF_TMO    = 15;
  localparam int unsigned DEF_PERIOD = 1024;
  localparam logic [15:0] CLEAR_DATA = 16'h0000;

endpackage

// File: rtl/cap_poller_tick_gen.sv
// Free-running period counter producing a registered one-cycle tick every
// PERIOD cycles.
module cap_tick_gen
  import wfd_wb_pkg::*;
#(
  parameter int unsigned PERIOD = DEF_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    tick_d = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/cap_poller.sv
// Wishbone initiator that reads 2**ADRBITS words into result, optionally
// clears word 0, and aborts on ack timeout. Auto-scan: CAP_POLLER_AUTO_EN.
module cap_poller
  import wfd_wb_pkg::*;
#(
  parameter int unsigned ADRBITS = 1,
  parameter int unsigned TMO     = DEF_TMO,
  parameter int unsigned PERIOD  = DEF_PERIOD
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst_n,
  input  logic                        start,
  input  logic                        clear_en,
  output logic                        wb_cyc,
  output logic                        wb_stb,
  output logic                        wb_we,
  output logic [ADRBITS-1:0]          wb_adr,
  output logic [15:0]                 wb_dat_o,
  input  logic [15:0]                 wb_dat_i,
  input  logic                        wb_ack,
  output logic [16*(2**ADRBITS)-1:0]  result,
  output logic                        valid,
  output logic                        busy,
  output logic                        err
);

  localparam int unsigned RW = 16 * (2**ADRBITS);
  localparam int unsigned CW = $clog2(TMO + 1);
  localparam logic [ADRBITS-1:0] LAST_IDX = '1;
  localparam logic [CW-1:0]      TMO_C    = CW'(TMO);

  logic start_scan;

`ifdef CAP_POLLER_AUTO_EN
  logic tick;

  cap_tick_gen #(.PERIOD(PERIOD)) u_tick (
    .clk   (wb_clk),
    .rst_n (wb_rst_n),
    .tick  (tick)
  );

  assign start_scan = start | tick;
`else
  assign start_scan = start;
`endif

  state_e             state_q, state_d;
  logic [ADRBITS-1:0] idx_q, idx_d;
  logic               clr_q, clr_d;
  logic               wr_pend_q, wr_pend_d;
  logic [CW-1:0]      tmo_q, tmo_d, tmo_inc;
  logic [RW-1:0]      result_q, result_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [ADRBITS-1:0] adr_q, adr_d;
  logic [15:0]        dat_q, dat_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    clr_d     = clr_q;
    wr_pend_d = wr_pend_q;
    tmo_d     = tmo_q;
    result_d  = result_q;
    err_d     = err_q;
    tmo_inc   = tmo_q + CW'(1);

    unique case (state_q)
      IDLE: begin
        if (start_scan) begin
          clr_d     = clear_en;
          err_d     = 1'b0;
          idx_d     = '0;
          wr_pend_d = 1'b0;
          tmo_d     = '0;
          state_d   = RD;
        end
      end
      RD: begin
        if (wb_ack) begin
          result_d[16*idx_q +: 16] = wb_dat_i;
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + ADRBITS'(1);
            state_d = RD_GAP;
          end else if (clr_q) begin
            // Reuse the read gap in front of the clearing write.
            wr_pend_d = 1'b1;
            state_d   = RD_GAP;
          end else begin
            state_d = DONE;
          end
        end else if (tmo_inc == TMO_C) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      RD_GAP: begin
        tmo_d   = '0;
        state_d = wr_pend_q ? WR : RD;
      end
      WR: begin
        if (wb_ack) begin
          wr_pend_d = 1'b0;
          state_d   = DONE;
        end else if (tmo_inc == TMO_C) begin
          wr_pend_d = 1'b0;
          err_d     = 1'b1;
          state_d   = DONE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered from the next state so they line up with it.
    cyc_d   = (state_d == RD) || (state_d == WR);
    we_d    = (state_d == WR);
    adr_d   = (state_d == RD) ? idx_d : '0;
    dat_d   = (state_d == WR) ? CLEAR_DATA : '0;
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      clr_q     <= 1'b0;
      wr_pend_q <= 1'b0;
      tmo_q     <= '0;
      result_q  <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      clr_q     <= clr_d;
      wr_pend_q <= wr_pend_d;
      tmo_q     <= tmo_d;
      result_q  <= result_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign wb_cyc   = cyc_q;
  assign wb_stb   = cyc_q;
  assign wb_we    = we_q;
  assign wb_adr   = adr_q;
  assign wb_dat_o = dat_q;
  assign result   = result_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule
